// File: rtl/ram_copy_engine.sv
// ram_copy_engine: word-by-word block copy inside the RAM window
// [ADDR_BASE, ADDR_BASE+MEM_SIZE-1], driving the read and write ports of
// ram_memory behind a start/busy/done/error handshake.
// Optional feature macro: RAM_COPY_CHECKSUM_EN adds a running sum of the
// words written in the current transfer on output port `checksum`.
module ram_copy_engine #(
  parameter int BUS_WIDTH    = 32,
  parameter int ADDR_BASE    = 10,
  parameter int MEM_SIZE     = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] src_addr,
  input  logic [BUS_WIDTH-1:0] dst_addr,
  input  logic [BUS_WIDTH-1:0] length,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [BUS_WIDTH-1:0] addr_read,
  input  logic [BUS_WIDTH-1:0] data_read,
  output logic                 write_en,
  output logic [BUS_WIDTH-1:0] addr_write,
`ifdef RAM_COPY_CHECKSUM_EN
  output logic [BUS_WIDTH-1:0] checksum,
`endif
  output logic [BUS_WIDTH-1:0] data_write
);

  if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
    $error("ram_copy_engine: READ_LATENCY must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  // Window bounds widened by one bit so start+length never wraps.
  localparam logic [BUS_WIDTH:0] WIN_LO  = (BUS_WIDTH+1)'(ADDR_BASE);
  localparam logic [BUS_WIDTH:0] WIN_END = (BUS_WIDTH+1)'(ADDR_BASE + MEM_SIZE);
  localparam bit DIRECT_READ = (READ_LATENCY == 0);

  state_t               state_q, state_d;
  logic [BUS_WIDTH-1:0] src_q, src_d;
  logic [BUS_WIDTH-1:0] dst_q, dst_d;
  logic [BUS_WIDTH-1:0] len_q, len_d;
  logic [BUS_WIDTH-1:0] idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [BUS_WIDTH-1:0] addr_read_q, addr_read_d;
  logic                 write_en_q, write_en_d;
  logic [BUS_WIDTH-1:0] addr_write_q, addr_write_d;
  // data_write_q doubles as the word buffer: it is loaded with the read
  // word at the same edge that enters WRITE and is held afterwards.
  logic [BUS_WIDTH-1:0] data_write_q, data_write_d;

  logic [BUS_WIDTH:0]   src_end;
  logic [BUS_WIDTH:0]   dst_end;
  logic                 range_bad;
  logic [BUS_WIDTH-1:0] idx_next;
  logic                 capture;

  // Range test for the latched request and per-word helpers.
  always_comb begin
    src_end   = {1'b0, src_q} + {1'b0, len_q};
    dst_end   = {1'b0, dst_q} + {1'b0, len_q};
    range_bad = ({1'b0, src_q} < WIN_LO) || (src_end > WIN_END) ||
                ({1'b0, dst_q} < WIN_LO) || (dst_end > WIN_END);
    idx_next  = idx_q + 1'b1;
    capture   = (state_q == S_WAIT) || (DIRECT_READ && (state_q == S_READ));
  end

  // Next-state and next-output logic; outputs are registered so they line
  // up with the state they belong to.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    idx_d        = idx_q;
    error_d      = error_q;
    addr_read_d  = addr_read_q;
    addr_write_d = addr_write_q;
    data_write_d = data_write_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = length;
          idx_d   = '0;
          error_d = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (len_q == '0) begin
          state_d = S_FIN;
        end else if (range_bad) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else begin
          addr_read_d = src_q;
          state_d     = S_READ;
        end
      end
      S_READ: begin
        if (DIRECT_READ) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        idx_d = idx_next;
        if (idx_next == len_q) begin
          state_d = S_FIN;
        end else begin
          addr_read_d = src_q + idx_next;
          state_d     = S_READ;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (capture) begin
      addr_write_d = dst_q + idx_q;
      data_write_d = data_read;
    end

    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FIN);
    write_en_d = (state_d == S_WRITE);
  end

  // FSM state, request latches and registered outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      addr_read_q  <= '0;
      write_en_q   <= 1'b0;
      addr_write_q <= '0;
      data_write_q <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      addr_read_q  <= addr_read_d;
      write_en_q   <= write_en_d;
      addr_write_q <= addr_write_d;
      data_write_q <= data_write_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign addr_read  = addr_read_q;
  assign write_en   = write_en_q;
  assign addr_write = addr_write_q;
  assign data_write = data_write_q;

`ifdef RAM_COPY_CHECKSUM_EN
  logic [BUS_WIDTH-1:0] checksum_q, checksum_d;

  // Running modulo-2^BUS_WIDTH sum, restarted by each accepted request.
  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == S_IDLE) && start) begin
      checksum_d = '0;
    end else if (capture) begin
      checksum_d = checksum_q + data_read;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_ram_copy_engine.sv
// tb_ram_copy_engine: directed bench for ram_copy_engine with a small
// behavioural RAM (READ_LATENCY=1) attached to its ports.
module tb_ram_copy_engine;

  logic        clk;
  logic        nreset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [31:0] length;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] addr_read;
  logic [31:0] data_read;
  logic        write_en;
  logic [31:0] addr_write;
  logic [31:0] data_write;
`ifdef RAM_COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  logic [31:0] mem [0:63];
  int          wr_count;
  int          errors;
  int          checks;

  ram_copy_engine #(
    .BUS_WIDTH   (32),
    .ADDR_BASE   (10),
    .MEM_SIZE    (32),
    .READ_LATENCY(1)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .addr_read (addr_read),
    .data_read (data_read),
    .write_en  (write_en),
    .addr_write(addr_write),
`ifdef RAM_COPY_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .data_write(data_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read (old data on read/write collision), write on edge.
  always @(posedge clk) begin
    data_read <= mem[addr_read[5:0]];
    if (write_en) begin
      mem[addr_write[5:0]] = data_write;
      wr_count++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and count negedges after the sampling edge until done.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d,
                          input logic [31:0] l, output int lat);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    length   = l;
    start    = 1'b1;
    wr_count = 0;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    logic ok;
    errors   = 0;
    checks   = 0;
    wr_count = 0;
    nreset   = 1'b0;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length   = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[10] = 32'd1;
    mem[11] = 32'd2;
    mem[12] = 32'd3;
    mem[13] = 32'd4;
    mem[30] = 32'hAA;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    check("rst_write_en", {31'b0, write_en}, 32'd0);
    check("rst_addr_read", addr_read, 32'd0);
    check("rst_addr_write", addr_write, 32'd0);
    check("rst_data_write", data_write, 32'd0);
    nreset = 1'b1;

    // 4-word copy 10..13 -> 20..23
    run_xfer(32'd10, 32'd20, 32'd4, lat);
    check("t1_latency", 32'(lat), 32'd14);
    check("t1_busy_at_done", {31'b0, busy}, 32'd1);
    check("t1_write_en_at_done", {31'b0, write_en}, 32'd0);
    check("t1_error", {31'b0, error}, 32'd0);
    check("t1_writes", 32'(wr_count), 32'd4);
    check("t1_mem20", mem[20], 32'd1);
    check("t1_mem21", mem[21], 32'd2);
    check("t1_mem22", mem[22], 32'd3);
    check("t1_mem23", mem[23], 32'd4);
    @(negedge clk);
    check("t1_idle_busy", {31'b0, busy}, 32'd0);

    // zero length
    run_xfer(32'd10, 32'd30, 32'd0, lat);
    check("t2_latency", 32'(lat), 32'd2);
    check("t2_error", {31'b0, error}, 32'd0);
    check("t2_writes", 32'(wr_count), 32'd0);
    check("t2_mem30", mem[30], 32'hAA);

    // source window runs past the top of RAM
    run_xfer(32'd40, 32'd20, 32'd3, lat);
    check("t3_latency", 32'(lat), 32'd2);
    check("t3_error", {31'b0, error}, 32'd1);
    check("t3_writes", 32'(wr_count), 32'd0);
    repeat (3) @(negedge clk);
    check("t3_error_sticky", {31'b0, error}, 32'd1);
    run_xfer(32'd10, 32'd24, 32'd1, lat);
    check("t3_legal_latency", 32'(lat), 32'd5);
    check("t3_error_cleared", {31'b0, error}, 32'd0);
    check("t3_mem24", mem[24], 32'd1);
    // destination below the window
    run_xfer(32'd10, 32'd5, 32'd1, lat);
    check("t3_dst_low_error", {31'b0, error}, 32'd1);
    check("t3_dst_low_writes", 32'(wr_count), 32'd0);

    // upper edge: last word at 41 is legal, 42 is not
    run_xfer(32'd10, 32'd41, 32'd1, lat);
    check("t4_edge_latency", 32'(lat), 32'd5);
    check("t4_edge_error", {31'b0, error}, 32'd0);
    check("t4_mem41", mem[41], 32'd1);
    run_xfer(32'd10, 32'd41, 32'd2, lat);
    check("t4_over_error", {31'b0, error}, 32'd1);
    check("t4_over_writes", 32'(wr_count), 32'd0);

    // reset during the third write of a 4-word copy; start pulsed while busy
    mem[22] = 32'h55;
    mem[23] = 32'h55;
    @(negedge clk);
    src_addr = 32'd10;
    dst_addr = 32'd20;
    length   = 32'd4;
    start    = 1'b1;
    wr_count = 0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    src_addr = 32'd10;
    dst_addr = 32'd30;
    length   = 32'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_busy_during", {31'b0, busy}, 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (write_en && wr_count == 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("t5_third_write_seen", {31'b0, ok}, 32'd1);
    nreset = 1'b0;
    #1;
    check("t5_rst_write_en", {31'b0, write_en}, 32'd0);
    check("t5_rst_busy", {31'b0, busy}, 32'd0);
    check("t5_rst_done", {31'b0, done}, 32'd0);
    check("t5_rst_addr_read", addr_read, 32'd0);
    check("t5_rst_addr_write", addr_write, 32'd0);
    check("t5_rst_data_write", data_write, 32'd0);
    repeat (2) @(negedge clk);
    check("t5_mem22", mem[22], 32'h55);
    check("t5_mem23", mem[23], 32'h55);
    check("t5_mem30", mem[30], 32'hAA);
    check("t5_writes", 32'(wr_count), 32'd2);
    nreset = 1'b1;

    // engine works again after the abort
    run_xfer(32'd12, 32'd30, 32'd2, lat);
    check("t5_after_latency", 32'(lat), 32'd8);
    check("t5_after_mem30", mem[30], 32'd3);
    check("t5_after_mem31", mem[31], 32'd4);

`ifdef RAM_COPY_CHECKSUM_EN
    run_xfer(32'd10, 32'd20, 32'd4, lat);
    check("t6_sum_1234", checksum, 32'd10);
    mem[14] = 32'hFFFF_FFFF;
    mem[15] = 32'd2;
    run_xfer(32'd14, 32'd26, 32'd2, lat);
    check("t6_sum_wrap", checksum, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
